// File: rtl/riscv_alu.sv
// riscv_alu: 32-bit integer ALU for the RISC-V datapath.
// The operation is combinational and both outputs are registered, so results
// appear one cycle after their operands. zero_bit drives the BEQ/BNE branch
// decision and is registered from the same value as result, so the two always agree.
module riscv_alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [3:0]       control_signal,
  input  logic             clk,
  output logic [WIDTH-1:0] result,
  output logic             zero_bit,
  input  logic             reset
);

  localparam int SHAMT_W = $clog2(WIDTH);

  // These encodings come from the ALU control unit.
  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SRL  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLT  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLTU = 4'b0111,
    OP_SLL  = 4'b1000,
    OP_SRA  = 4'b1001,
    OP_NOR  = 4'b1100
  } alu_op_e;

  logic [WIDTH-1:0]   w_alu;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;

  // Shifts use only the low log2(WIDTH) bits of operand B. Higher bits are ignored.
  assign w_shamt = read_data2[SHAMT_W-1:0];

  // Compute the operation selected by control_signal.
  always_comb begin
    // NOTE: assigning a default first means every path writes w_alu, so no latch is inferred.
    w_alu = '0;
    case (control_signal)
      OP_AND:  w_alu = read_data1 & read_data2;
      OP_OR:   w_alu = read_data1 | read_data2;
      OP_ADD:  w_alu = read_data1 + read_data2;
      OP_SRL:  w_alu = read_data1 >> w_shamt;
      OP_XOR:  w_alu = read_data1 ^ read_data2;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(read_data1) < $signed(read_data2))};
      OP_SUB:  w_alu = read_data1 - read_data2;
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (read_data1 < read_data2)};
      OP_SLL:  w_alu = read_data1 << w_shamt;
      OP_SRA:  w_alu = WIDTH'($signed(read_data1) >>> w_shamt);
      OP_NOR:  w_alu = ~(read_data1 | read_data2);
      default: w_alu = '0;
    endcase
  end

  // Register the result and its zero flag. Synchronous reset has priority.
  always_ff @(posedge clk) begin
    // NOTE: use non-blocking assignments for state so every register samples the pre-edge values.
    if (reset) begin
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_result <= w_alu;
      r_zero   <= (w_alu == '0);
    end
  end

  assign result   = r_result;
  assign zero_bit = r_zero;

endmodule

// File: tb/tb_riscv_alu.sv
// tb_riscv_alu: directed vectors with hand-computed expected results for riscv_alu.
module tb_riscv_alu;

  logic        clk;
  logic        reset;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [3:0]  control_signal;
  logic [31:0] result;
  logic        zero_bit;

  int n_cmp = 0;
  int n_err = 0;

  riscv_alu #(.WIDTH(32)) dut (
    .read_data1     (read_data1),
    .read_data2     (read_data2),
    .control_signal (control_signal),
    .clk            (clk),
    .result         (result),
    .zero_bit       (zero_bit),
    .reset          (reset)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one operation, clock it in, then check both outputs 1 ns after the edge.
  task automatic apply(input string tag, input logic rst, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] code,
                       input logic [31:0] exp_res, input logic exp_zero);
    reset          = rst;
    read_data1     = a;
    read_data2     = b;
    control_signal = code;
    @(posedge clk);
    #1;
    check({tag, ".result"}, result, exp_res);
    check({tag, ".zero"}, {31'b0, zero_bit}, {31'b0, exp_zero});
  endtask

  initial begin
    reset          = 1'b1;
    read_data1     = 32'hDEAD_BEEF;
    read_data2     = 32'h1234_5678;
    control_signal = 4'b0010;
    #2;

    // 1. Reset, then reset held while AND is selected.
    apply("reset",      1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 4'b0010, 32'd0, 1'b1);
    apply("reset_hold", 1'b1, 32'd12, 32'd12, 4'b0000, 32'd0, 1'b1);

    // 2. A=B=12 across the basic ops.
    apply("and12", 1'b0, 32'd12, 32'd12, 4'b0000, 32'd12, 1'b0);
    apply("or12",  1'b0, 32'd12, 32'd12, 4'b0001, 32'd12, 1'b0);
    apply("add12", 1'b0, 32'd12, 32'd12, 4'b0010, 32'd24, 1'b0);
    apply("sub12", 1'b0, 32'd12, 32'd12, 4'b0110, 32'd0,  1'b1);
    apply("xor12", 1'b0, 32'd12, 32'd12, 4'b0100, 32'd0,  1'b1);
    apply("slt12", 1'b0, 32'd12, 32'd12, 4'b0101, 32'd0,  1'b1);

    // 3. Wrap and sign cases.
    apply("add_wrap",  1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1'b1);
    apply("sub_wrap",  1'b0, 32'd0, 32'd1, 4'b0110, 32'hFFFF_FFFF, 1'b0);
    apply("slt_neg",   1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0101, 32'd1, 1'b0);
    apply("sltu_big",  1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0111, 32'd0, 1'b1);
    apply("sltu_small",1'b0, 32'd1, 32'hFFFF_FFFF, 4'b0111, 32'd1, 1'b0);
    apply("slt_pos",   1'b0, 32'd1, 32'hFFFF_FFFF, 4'b0101, 32'd0, 1'b1);

    // 4. Shifts.
    apply("sll4",    1'b0, 32'h8000_0010, 32'd4,    4'b1000, 32'h0000_0100, 1'b0);
    apply("srl4",    1'b0, 32'h8000_0010, 32'd4,    4'b0011, 32'h0800_0001, 1'b0);
    apply("sra4",    1'b0, 32'h8000_0010, 32'd4,    4'b1001, 32'hF800_0001, 1'b0);
    apply("srl_x24", 1'b0, 32'h8000_0010, 32'h24,   4'b0011, 32'h0800_0001, 1'b0);
    apply("sra0",    1'b0, 32'h8000_0010, 32'h20,   4'b1001, 32'h8000_0010, 1'b0);
    apply("sll31",   1'b0, 32'h0000_0003, 32'd31,   4'b1000, 32'h8000_0000, 1'b0);
    apply("sra_pos", 1'b0, 32'h7000_0000, 32'd28,   4'b1001, 32'h0000_0007, 1'b0);

    // 5. NOR and an undefined code.
    apply("nor00",  1'b0, 32'd0, 32'd0, 4'b1100, 32'hFFFF_FFFF, 1'b0);
    apply("nor_mix",1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 4'b1100, 32'h0F0F_F0F0, 1'b0);
    apply("undef",  1'b0, 32'd5, 32'd3, 4'b1111, 32'd0, 1'b1);
    apply("undef_a",1'b0, 32'd5, 32'd3, 4'b1010, 32'd0, 1'b1);

    // 6. Back-to-back operations with reset asserted for one cycle.
    apply("b2b_add", 1'b0, 32'd1, 32'd2, 4'b0010, 32'd3, 1'b0);
    apply("b2b_rst", 1'b1, 32'd5, 32'd5, 4'b0010, 32'd0, 1'b1);
    apply("b2b_or",  1'b0, 32'd4, 32'd1, 4'b0001, 32'd5, 1'b0);
    apply("b2b_xor", 1'b0, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 4'b0100, 32'hAAAA_AAAA, 1'b0);

    // Outputs hold their value until the next edge.
    #3;
    check("hold.result", result, 32'hAAAA_AAAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_alu.md
Name: riscv_alu

Overview:
- 32-bit integer ALU for the single-cycle/pipelined RISC-V datapath.
- Takes two register-file operands and a 4-bit ALU control code from the ALU control unit.
- Produces a registered result plus a zero flag used by branch logic (BEQ/BNE).
- The output register updates on the rising edge of clk; reset is synchronous.

Parameters:
- WIDTH, 32, operand/result width in bits. Shift amount uses the low log2(WIDTH) bits of read_data2 (5 bits at default).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- read_data1  input  WIDTH  operand A (rs1).
- read_data2  input  WIDTH  operand B (rs2 or immediate).
- control_signal  input  4  operation select.
- result  output  WIDTH  registered operation result.
- zero_bit  output  1  registered flag, 1 when result == 0.
- Positional port order: read_data1, read_data2, control_signal, clk, result, zero_bit, reset. Reset is appended last so existing positional instantiations keep their mapping.

Behaviour:
- One clock; reset is synchronous and active-high. The clock port is clk and the reset port is reset.
- On a rising clk edge with reset=1: result <= 0, zero_bit <= 1. Reset has priority over any operation.
- On a rising clk edge with reset=0: result <= f(read_data1, read_data2, control_signal), and zero_bit <= (f == 0).
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N and are held until the next edge.
- No handshake; a new operation may be issued every cycle.
- Operation codes:
  - 0000 AND: A & B
  - 0001 OR: A | B
  - 0010 ADD: A + B, modulo 2^WIDTH; carry discarded; no overflow flag.
  - 0011 SRL: A >> B[4:0], logical, zero fill.
  - 0100 XOR: A ^ B
  - 0101 SLT: 1 if signed(A) < signed(B), else 0; zero-extended to WIDTH.
  - 0110 SUB: A - B, modulo 2^WIDTH; wraps silently.
  - 0111 SLTU: 1 if unsigned(A) < unsigned(B), else 0.
  - 1000 SLL: A << B[4:0]
  - 1001 SRA: A >>> B[4:0], arithmetic, sign fill.
  - 1100 NOR: ~(A | B)
  - All other codes: result 0, zero_bit 1.
- Shifts ignore read_data2 bits above [4:0]. A shift of 0 passes A unchanged.
- The zero_bit register is always consistent with the result register in the same cycle.
- Before the first reset or clock edge the outputs are undefined. The bench must apply reset first.

Test Plan:
1. Assert reset for 1 cycle with any inputs -> result=0, zero_bit=1. Then with reset=1 held and AND selected on 12,12 -> outputs stay 0/1.
2. A=12, B=12, one code per cycle in the order 0000, 0001, 0010, 0110, 0100, 0101 -> one cycle later each: AND=12 (zero 0), OR=12 (zero 0), ADD=24 (zero 0), SUB=0 (zero 1), XOR=0 (zero 1), SLT=0 (zero 1).
3. Wrap and sign cases:
   - ADD 0xFFFFFFFF+1 -> 0, zero 1.
   - SUB 0-1 -> 0xFFFFFFFF.
   - SLT A=0xFFFFFFFF, B=1 -> 1.
   - SLTU with the same operands -> 0.
4. Shifts with A=0x80000010:
   - SLL B=4 -> 0x00000100.
   - SRL B=4 -> 0x08000001.
   - SRA B=4 -> 0xF8000001.
   - SRL with B=0x24 (uses 4) -> 0x08000001.
5. NOR 0,0 -> 0xFFFFFFFF, zero 0. Undefined code 1111 with A=5, B=3 -> result 0, zero 1.
6. Back-to-back ops with reset asserted mid-stream for one cycle -> that cycle's output is 0/1, and the next operation's result appears on the following cycle.
